// File: rtl/prop_mon_pkg.sv
// Purpose: shared types and the antecedent-hit helper for the prop_mon_chk checker.
// Latency: n/a (types and a combinational function only).
// Backpressure: none.
package prop_mon_pkg;

  // Antecedent mode per channel, encoded as on cfg_mode.
  typedef enum logic [1:0] {
    MODE_RISE  = 2'b00,
    MODE_FALL  = 2'b01,
    MODE_ANY   = 2'b10,
    MODE_LEVEL = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Antecedent hit from the current trigger sample and the previous one.
  function automatic logic mode_hit(input mode_e mode, input logic trig, input logic trig_q);
    logic hit;
    case (mode)
      MODE_RISE: hit = trig & ~trig_q;
      MODE_FALL: hit = ~trig & trig_q;
      MODE_ANY:  hit = trig ^ trig_q;
      default:   hit = trig;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/prop_mon_chk_if.sv
// Purpose: bundles the checker's configuration, observed signals and results.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is sampled or presented each cycle.
// Ports: master drives enable/clr_cnt/cfg_*/trig/sig and observes the results;
//        slave (the checker) drives pass_p/fail_p/ovl_p/busy/pass_cnt/fail_cnt.
interface prop_mon_chk_if #(
  parameter int NUM_CH = 4,
  parameter int WIN_W  = 4,
  parameter int CNT_W  = 16
) ();
  logic                     enable;
  logic                     clr_cnt;
  logic [2*NUM_CH-1:0]      cfg_mode;
  logic [NUM_CH-1:0]        cfg_exp;
  logic [WIN_W-1:0]         cfg_win;
  logic [NUM_CH-1:0]        trig;
  logic [NUM_CH-1:0]        sig;
  logic [NUM_CH-1:0]        pass_p;
  logic [NUM_CH-1:0]        fail_p;
  logic [NUM_CH-1:0]        ovl_p;
  logic [NUM_CH-1:0]        busy;
  logic [NUM_CH*CNT_W-1:0]  pass_cnt;
  logic [NUM_CH*CNT_W-1:0]  fail_cnt;

  modport master (
    output enable, clr_cnt, cfg_mode, cfg_exp, cfg_win, trig, sig,
    input  pass_p, fail_p, ovl_p, busy, pass_cnt, fail_cnt
  );

  modport slave (
    input  enable, clr_cnt, cfg_mode, cfg_exp, cfg_win, trig, sig,
    output pass_p, fail_p, ovl_p, busy, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/prop_mon_chan.sv
// Purpose: one implication-check channel (edge detect, IDLE/WAIT FSM, window count, counters).
// Latency: pass/fail/ovl pulses and counter updates appear one edge after the evaluating edge.
// Backpressure: none; a hit while busy is reported on ovl_p and dropped.
// Ports: clk/rst_n, enable/clr_cnt, mode/exp_val/cfg_win config, trig/sig in;
//        pass_p/fail_p/ovl_p/busy pulses and pass_cnt/fail_cnt saturating counts out.
module prop_mon_chan
  import prop_mon_pkg::*;
#(
  parameter int WIN_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clr_cnt,
  input  mode_e            mode,
  input  logic             exp_val,
  input  logic [WIN_W-1:0] cfg_win,
  input  logic             trig,
  input  logic             sig,
  output logic             pass_p,
  output logic             fail_p,
  output logic             ovl_p,
  output logic             busy,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  logic             trig_q, trig_d;
  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [WIN_W-1:0] wcnt_q, wcnt_d;
  logic             pass_q, pass_d, fail_q, fail_d, ovl_q, ovl_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
  logic             hit, match;

  always_comb begin
    trig_d  = trig;
    hit     = mode_hit(mode, trig, trig_q);
    match   = (sig == exp_val);
    state_d = state_q;
    win_d   = win_q;
    wcnt_d  = wcnt_q;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
    ovl_d   = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hit) begin
            if (match) begin
              pass_d = 1'b1;
            end else if (cfg_win == '0) begin
              fail_d = 1'b1;
            end else begin
              // Window is latched here so later cfg_win changes leave this check alone.
              win_d   = cfg_win;
              wcnt_d  = {{(WIN_W-1){1'b0}}, 1'b1};
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // Any hit while waiting (even on the resolving edge) is dropped.
          ovl_d = hit;
          if (match) begin
            pass_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (wcnt_q == win_q) begin
            fail_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Clear has priority over a coincident event; the pulse itself still fires.
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (clr_cnt) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
    end else begin
      if (pass_d && (pass_cnt_q != {CNT_W{1'b1}})) pass_cnt_d = pass_cnt_q + 1'b1;
      if (fail_d && (fail_cnt_q != {CNT_W{1'b1}})) fail_cnt_d = fail_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q     <= 1'b0;
      state_q    <= ST_IDLE;
      win_q      <= '0;
      wcnt_q     <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      ovl_q      <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      trig_q     <= trig_d;
      state_q    <= state_d;
      win_q      <= win_d;
      wcnt_q     <= wcnt_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      ovl_q      <= ovl_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign pass_p   = pass_q;
  assign fail_p   = fail_q;
  assign ovl_p    = ovl_q;
  assign busy     = (state_q == ST_WAIT);
  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;

endmodule

// File: rtl/prop_mon_chk.sv
// Purpose: NUM_CH-channel synthesizable implication checker (trig |-> ##[0:cfg_win] sig==cfg_exp).
// Latency: results registered, visible one edge after the evaluating edge.
// Backpressure: none; overlapping antecedents pulse ovl_p and are dropped.
// Ports: clk, rst_n (async active-low), mon (prop_mon_chk_if.slave) carrying config,
//        trig/sig and all per-channel results.
// Optional: define PROP_MON_TIMESTAMP_EN to add ff_vld/ff_ch/ff_ts first-fail capture
//           driven by a free-running TS_W-bit cycle counter.
module prop_mon_chk
  import prop_mon_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIN_W  = 4,
  parameter int CNT_W  = 16
`ifdef PROP_MON_TIMESTAMP_EN
  , parameter int TS_W = 32
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  prop_mon_chk_if.slave mon
`ifdef PROP_MON_TIMESTAMP_EN
  , output logic                                          ff_vld
  , output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ff_ch
  , output logic [TS_W-1:0]                               ff_ts
`endif
);

  logic [NUM_CH-1:0]       pass_v, fail_v, ovl_v, busy_v;
  logic [NUM_CH*CNT_W-1:0] pass_cnt_v, fail_cnt_v;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    prop_mon_chan #(.WIN_W(WIN_W), .CNT_W(CNT_W)) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (mon.enable),
      .clr_cnt  (mon.clr_cnt),
      .mode     (mode_e'(mon.cfg_mode[2*i +: 2])),
      .exp_val  (mon.cfg_exp[i]),
      .cfg_win  (mon.cfg_win),
      .trig     (mon.trig[i]),
      .sig      (mon.sig[i]),
      .pass_p   (pass_v[i]),
      .fail_p   (fail_v[i]),
      .ovl_p    (ovl_v[i]),
      .busy     (busy_v[i]),
      .pass_cnt (pass_cnt_v[i*CNT_W +: CNT_W]),
      .fail_cnt (fail_cnt_v[i*CNT_W +: CNT_W])
    );
  end

  assign mon.pass_p   = pass_v;
  assign mon.fail_p   = fail_v;
  assign mon.ovl_p    = ovl_v;
  assign mon.busy     = busy_v;
  assign mon.pass_cnt = pass_cnt_v;
  assign mon.fail_cnt = fail_cnt_v;

`ifdef PROP_MON_TIMESTAMP_EN
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [TS_W-1:0] ts_q, ts_d, ff_ts_q, ff_ts_d;
  logic [CH_W-1:0] ff_ch_q, ff_ch_d, first_ch;
  logic            ff_vld_q, ff_vld_d;

  always_comb begin
    ts_d     = ts_q + 1'b1;
    ff_vld_d = ff_vld_q;
    ff_ch_d  = ff_ch_q;
    ff_ts_d  = ff_ts_q;
    // Descending scan leaves the lowest failing channel index.
    first_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (fail_v[i]) first_ch = CH_W'(i);
    end
    if (mon.clr_cnt) begin
      ff_vld_d = 1'b0;
      ff_ch_d  = '0;
      ff_ts_d  = '0;
    end else if (!ff_vld_q && (|fail_v)) begin
      ff_vld_d = 1'b1;
      ff_ch_d  = first_ch;
      ff_ts_d  = ts_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q     <= '0;
      ff_vld_q <= 1'b0;
      ff_ch_q  <= '0;
      ff_ts_q  <= '0;
    end else begin
      ts_q     <= ts_d;
      ff_vld_q <= ff_vld_d;
      ff_ch_q  <= ff_ch_d;
      ff_ts_q  <= ff_ts_d;
    end
  end

  assign ff_vld = ff_vld_q;
  assign ff_ch  = ff_ch_q;
  assign ff_ts  = ff_ts_q;
`endif

endmodule

// File: tb/tb_prop_mon_chk.sv
// Purpose: scoreboard bench for prop_mon_chk with a deadline-based reference model.
// Latency: model predicts outputs visible after each posedge; monitor compares at negedge.
// Backpressure: none.
module tb_prop_mon_chk;

  localparam int NC = 4;
  localparam int WW = 4;
  localparam int CW = 16;

  typedef struct packed {
    logic [NC-1:0]         pass;
    logic [NC-1:0]         fail;
    logic [NC-1:0]         ovl;
    logic [NC-1:0]         busy;
    logic [NC-1:0][CW-1:0] pc;
    logic [NC-1:0][CW-1:0] fc;
    logic [NC-1:0][1:0]    pc2;
    logic [NC-1:0][1:0]    fc2;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic            enable   = 1'b0;
  logic            clr_cnt  = 1'b0;
  logic [2*NC-1:0] cfg_mode = '0;
  logic [NC-1:0]   cfg_exp  = '0;
  logic [WW-1:0]   cfg_win  = '0;
  logic [NC-1:0]   trig     = '0;
  logic [NC-1:0]   sig      = '0;

  prop_mon_chk_if #(.NUM_CH(NC), .WIN_W(WW), .CNT_W(CW)) mif ();
  prop_mon_chk_if #(.NUM_CH(NC), .WIN_W(WW), .CNT_W(2))  mif2 ();

  assign mif.enable   = enable;   assign mif2.enable   = enable;
  assign mif.clr_cnt  = clr_cnt;  assign mif2.clr_cnt  = clr_cnt;
  assign mif.cfg_mode = cfg_mode; assign mif2.cfg_mode = cfg_mode;
  assign mif.cfg_exp  = cfg_exp;  assign mif2.cfg_exp  = cfg_exp;
  assign mif.cfg_win  = cfg_win;  assign mif2.cfg_win  = cfg_win;
  assign mif.trig     = trig;     assign mif2.trig     = trig;
  assign mif.sig      = sig;      assign mif2.sig      = sig;

  prop_mon_chk #(.NUM_CH(NC), .WIN_W(WW), .CNT_W(CW)) dut  (.clk(clk), .rst_n(rst_n), .mon(mif.slave));
  prop_mon_chk #(.NUM_CH(NC), .WIN_W(WW), .CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .mon(mif2.slave));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  exp_t expq[$];

  // ---------------- reference model ----------------
  // An in-flight check is just a deadline cycle; counts are plain integers,
  // clipped to the counter width only when compared.
  logic [NC-1:0] m_prev = '0;
  bit            pend[NC];
  int            deadline[NC];
  int            pcnt[NC];
  int            fcnt[NC];

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    bit h, ok, p, f;
    e = '0;
    cyc++;
    if (!rst_n) begin
      m_prev = '0;
      for (int c = 0; c < NC; c++) begin
        pend[c] = 0; pcnt[c] = 0; fcnt[c] = 0;
      end
    end else begin
      for (int c = 0; c < NC; c++) begin
        case (cfg_mode[2*c +: 2])
          2'd0:    h = trig[c] && !m_prev[c];
          2'd1:    h = !trig[c] && m_prev[c];
          2'd2:    h = trig[c] != m_prev[c];
          default: h = trig[c];
        endcase
        ok = (sig[c] == cfg_exp[c]);
        p = 0; f = 0;
        if (!enable) begin
          pend[c] = 0;
        end else if (pend[c]) begin
          e.ovl[c] = h;
          if (ok) begin p = 1; pend[c] = 0; end
          else if (cyc >= deadline[c]) begin f = 1; pend[c] = 0; end
        end else if (h) begin
          if (ok) p = 1;
          else if (cfg_win == 0) f = 1;
          else begin pend[c] = 1; deadline[c] = cyc + int'(cfg_win); end
        end
        e.pass[c] = p;
        e.fail[c] = f;
        e.busy[c] = pend[c];
        if (clr_cnt) begin pcnt[c] = 0; fcnt[c] = 0; end
        else begin pcnt[c] += int'(p); fcnt[c] += int'(f); end
        e.pc[c]  = CW'(sat(pcnt[c], CW));
        e.fc[c]  = CW'(sat(fcnt[c], CW));
        e.pc2[c] = 2'(sat(pcnt[c], 2));
        e.fc2[c] = 2'(sat(fcnt[c], 2));
      end
      m_prev = trig;
    end
    expq.push_back(e);
  end

  // ---------------- monitor ----------------
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() == 0) begin
      chk("queue_nonempty", 128'd0, 128'd1);
    end else begin
      e = expq.pop_front();
      // Reset is asynchronous: while held, every output must already be 0.
      if (!rst_n) e = '0;
      chk("pulses_busy", {mif.pass_p, mif.fail_p, mif.ovl_p, mif.busy}, {e.pass, e.fail, e.ovl, e.busy});
      chk("pass_cnt",    mif.pass_cnt,  e.pc);
      chk("fail_cnt",    mif.fail_cnt,  e.fc);
      chk("pass_cnt_w2", mif2.pass_cnt, e.pc2);
      chk("fail_cnt_w2", mif2.fail_cnt, e.fc2);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_cfg(input logic [2*NC-1:0] m, input logic [NC-1:0] x, input logic [WW-1:0] w);
    enable = 1'b0;
    tick(1);
    cfg_mode = m; cfg_exp = x; cfg_win = w;
    enable = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;

    // Rise, same-cycle implication: single pass.
    set_cfg(8'b00_00_00_00, 4'b1111, 4'd0);
    sig = 4'b0001; tick(2);
    trig[0] = 1'b1; tick(1);
    trig[0] = 1'b0; tick(3);

    // Rise, window 3: sig arrives two cycles late -> pass.
    cfg_win = 4'd3; sig = '0; tick(2);
    trig[0] = 1'b1; tick(1);
    trig[0] = 1'b0; tick(1);
    sig[0]  = 1'b1; tick(1);
    sig[0]  = 1'b0; tick(4);
    // Window 2, sig never arrives -> fail.
    cfg_win = 4'd2;
    trig[0] = 1'b1; tick(1);
    trig[0] = 1'b0; tick(5);

    // Rise/fall/any/level on channels 0..3 together.
    set_cfg(8'b11_10_01_00, 4'b1111, 4'd0);
    sig = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      trig = NC'($urandom);
      tick(1);
    end
    trig = '0; tick(2);
    trig[3] = 1'b1; tick(5);
    trig[3] = 1'b0; tick(2);

    // Overlap: second rise two cycles into a 4-cycle window.
    set_cfg(8'b00_00_00_00, 4'b1111, 4'd4);
    sig = '0; trig = '0; tick(1);
    trig[0] = 1'b1; tick(1);
    trig[0] = 1'b0; tick(1);
    trig[0] = 1'b1; tick(1);
    trig[0] = 1'b0; tick(6);

    // Saturation of the 2-bit counters and clear coincident with a pass.
    set_cfg(8'b00_00_00_11, 4'b1111, 4'd0);
    sig = 4'b0001; trig = 4'b0001; tick(5);
    clr_cnt = 1'b1; tick(1);
    clr_cnt = 1'b0; trig = '0; tick(3);

    // Reset during WAIT, trig held high across release.
    set_cfg(8'b00_00_00_00, 4'b1111, 4'd5);
    sig = '0; trig = '0; tick(1);
    trig[0] = 1'b1; tick(1);
    #1 rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1; sig[0] = 1'b1;
    tick(3);
    trig = '0; sig = '0; tick(2);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      if (n % 60 == 0) set_cfg(8'($urandom), 4'($urandom), 4'($urandom_range(0, 6)));
      if (n % 7 == 0) cfg_win = 4'($urandom_range(0, 6));
      trig    = 4'($urandom);
      sig     = 4'($urandom);
      clr_cnt = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
      end
      tick(1);
    end
    clr_cnt = 1'b0; trig = '0; sig = '0;
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
